// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq
//   Sequential neuron. It accepts N_IN unsigned inputs with N_IN signed
//   Q.FRAC weights and an unsigned integer bias. It multiply-accumulates one
//   input per clock into a saturating accumulator, then applies a selectable
//   activation. The result is registered and offered on a valid/ready
//   handshake.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   in_valid/in_ready input handshake (in_ready high only in IDLE)
//   in_vec            N_IN x IN_W unsigned inputs, element i at [i*IN_W +: IN_W]
//   w_vec             N_IN x W_W signed weights, element i at [i*W_W +: W_W]
//   bias              unsigned integer bias, added as bias<<FRAC
//   act_sel           00 identity, 01 ReLU, 10 negate, 11 hard-sigmoid
//   out_valid/out_ready output handshake (out_valid high only in DONE)
//   out_data          signed Q(ACC_W-FRAC).FRAC result
//   overflow          saturation seen in this transaction
module neuron_mac_seq #(
  parameter int N_IN   = 4,
  parameter int IN_W   = 2,
  parameter int W_W    = 8,
  parameter int FRAC   = 4,
  parameter int BIAS_W = 3,
  parameter int ACC_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*IN_W-1:0]   in_vec,
  input  logic [N_IN*W_W-1:0]    w_vec,
  input  logic [BIAS_W-1:0]      bias,
  input  logic [1:0]             act_sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_data,
  output logic                   overflow
);

  localparam int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int PROD_W = IN_W + W_W + 1;
  // One guard bit above the wider operand, so the raw sum can never wrap.
  localparam int SUM_W  = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 1;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] SUM_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SUM_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W:0]   HS_HALF = {{ACC_W{1'b0}}, 1'b1} << (FRAC-1);
  localparam logic signed [ACC_W:0]   HS_ONE  = {{ACC_W{1'b0}}, 1'b1} << FRAC;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ACT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [N_IN*IN_W-1:0]    in_q, in_d;
  logic [N_IN*W_W-1:0]     w_q, w_d;
  logic [1:0]              act_q, act_d;
  logic [ACC_W-1:0]        out_data_q, out_data_d;
  logic                    overflow_q, overflow_d;

  // ---------------- MAC datapath ----------------
  logic [IN_W-1:0]          in_el;
  logic signed [W_W-1:0]    w_el;
  logic signed [PROD_W-1:0] prod;
  logic signed [SUM_W-1:0]  sum;
  logic signed [ACC_W-1:0]  mac_res;
  logic                     mac_sat;

  always_comb begin
    in_el = in_q[int'(idx_q)*IN_W +: IN_W];
    w_el  = w_q[int'(idx_q)*W_W +: W_W];
    // Zero-extend the unsigned input by one bit so the product is a true
    // signed multiply.
    prod  = $signed({1'b0, in_el}) * w_el;
    sum   = {{(SUM_W-ACC_W){acc_q[ACC_W-1]}}, acc_q}
          + {{(SUM_W-PROD_W){prod[PROD_W-1]}}, prod};
    mac_sat = 1'b0;
    if (sum > SUM_MAX) begin
      mac_res = ACC_MAX;
      mac_sat = 1'b1;
    end else if (sum < SUM_MIN) begin
      mac_res = ACC_MIN;
      mac_sat = 1'b1;
    end else begin
      mac_res = sum[ACC_W-1:0];
    end
  end

  // ---------------- activation ----------------
  logic signed [ACC_W:0] acc_wide, hs;
  logic [ACC_W-1:0]      act_res;
  logic                  act_ovf;

  always_comb begin
    acc_wide = {acc_q[ACC_W-1], acc_q};
    // Hard sigmoid y = x/4 + 0.5, evaluated one bit wider than acc.
    hs       = (acc_wide >>> 2) + HS_HALF;
    act_ovf  = 1'b0;
    case (act_q)
      2'b00: act_res = acc_q;
      2'b01: act_res = acc_q[ACC_W-1] ? '0 : acc_q;
      2'b10: begin
        // The most negative value has no positive twin; clamp and flag it.
        if (acc_q == ACC_MIN) begin
          act_res = ACC_MAX;
          act_ovf = 1'b1;
        end else begin
          act_res = -acc_q;
        end
      end
      default: begin
        if (hs < 0)            act_res = '0;
        else if (hs > HS_ONE)  act_res = HS_ONE[ACC_W-1:0];
        else                   act_res = hs[ACC_W-1:0];
      end
    endcase
  end

  // ---------------- control ----------------
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    in_d       = in_q;
    w_d        = w_q;
    act_d      = act_q;
    out_data_d = out_data_q;
    overflow_d = overflow_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          in_d       = in_vec;
          w_d        = w_vec;
          act_d      = act_sel;
          acc_d      = ACC_W'(bias) << FRAC;
          idx_d      = '0;
          overflow_d = 1'b0;
          state_d    = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = mac_res;
        if (mac_sat) overflow_d = 1'b1;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(N_IN-1)) state_d = S_ACT;
      end
      S_ACT: begin
        out_data_d = act_res;
        if (act_ovf) overflow_d = 1'b1;
        state_d    = S_DONE;
      end
      default: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: all state uses non-blocking assignment so every flop updates
      // from pre-edge values; the captured operands are reset as well so the
      // block leaves reset fully defined.
      state_q    <= S_IDLE;
      idx_q      <= '0;
      acc_q      <= '0;
      in_q       <= '0;
      w_q        <= '0;
      act_q      <= '0;
      out_data_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      in_q       <= in_d;
      w_q        <= w_d;
      act_q      <= act_d;
      out_data_q <= out_data_d;
      overflow_q <= overflow_d;
    end
  end

  // Handshake flags decode the registered state only.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = out_data_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Testbench for neuron_mac_seq. Three instances: default parameters,
// ACC_W=10 for saturation corners, and N_IN=8 for the longer latency.
module tb_neuron_mac_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // shared buses (default and ACC_W=10 instances)
  logic [7:0]  in_vec  = '0;
  logic [31:0] w_vec   = '0;
  logic [2:0]  bias    = '0;
  logic [1:0]  act_sel = '0;

  // default instance
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, overflow;
  logic [15:0] out_data;

  // ACC_W=10 instance
  logic        s_in_valid = 1'b0, s_out_ready = 1'b0;
  logic        s_in_ready, s_out_valid, s_overflow;
  logic [9:0]  s_out_data;

  // N_IN=8 instance
  logic        l_in_valid = 1'b0, l_out_ready = 1'b0;
  logic [15:0] l_in_vec = '0;
  logic [63:0] l_w_vec  = '0;
  logic        l_in_ready, l_out_valid, l_overflow;
  logic [15:0] l_out_data;

  neuron_mac_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .w_vec(w_vec), .bias(bias), .act_sel(act_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .overflow(overflow)
  );

  neuron_mac_seq #(.ACC_W(10)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_vec(in_vec), .w_vec(w_vec), .bias(bias), .act_sel(act_sel),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .overflow(s_overflow)
  );

  neuron_mac_seq #(.N_IN(8)) dut_l (
    .clk(clk), .rst(rst), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .in_vec(l_in_vec), .w_vec(l_w_vec), .bias(bias), .act_sel(act_sel),
    .out_valid(l_out_valid), .out_ready(l_out_ready), .out_data(l_out_data),
    .overflow(l_overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  typedef struct {
    logic [7:0]  in_v;
    logic [31:0] w_v;
    logic [2:0]  b;
    logic [1:0]  act;
    int          exp_data;
    int          exp_ovf;
  } vec_t;

  // in=(1,2,3,0), w=(16,8,-4,32)
  localparam logic [7:0]  IN_C1 = {2'd0, 2'd3, 2'd2, 2'd1};
  localparam logic [31:0] W_C1  = {8'd32, 8'hFC, 8'd8, 8'd16};
  localparam logic [7:0]  IN_3  = {2'd3, 2'd3, 2'd3, 2'd3};
  localparam logic [31:0] W_M128 = 32'h8080_8080;
  localparam logic [31:0] W_P127 = 32'h7F7F_7F7F;

  // Default instance: offer, accept, wait for out_valid (checking the
  // latency), sample, then complete the handshake.
  task automatic run_txn(input logic [7:0] iv, input logic [31:0] wv,
                         input logic [2:0] b, input logic [1:0] a,
                         output int data, output int ovf);
    int lat;
    @(negedge clk);
    in_vec = iv; w_vec = wv; bias = b; act_sel = a; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    check("txn_latency", lat, 5);
    data = int'($signed(out_data));
    ovf  = int'(overflow);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_sat(input logic [7:0] iv, input logic [31:0] wv,
                         input logic [2:0] b, input logic [1:0] a,
                         output int data, output int ovf);
    int lat;
    @(negedge clk);
    in_vec = iv; w_vec = wv; bias = b; act_sel = a; s_in_valid = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
    lat = 0;
    while (!s_out_valid && lat < 40) begin @(negedge clk); lat++; end
    check("sat_latency", lat, 5);
    data = int'($signed(s_out_data));
    ovf  = int'(s_overflow);
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[11];
    int   d, o, lat;

    vecs[0]  = '{IN_C1, W_C1, 3'd2, 2'b00, 52, 0};
    vecs[1]  = '{IN_C1, W_C1, 3'd2, 2'b01, 52, 0};
    vecs[2]  = '{IN_C1, W_C1, 3'd2, 2'b10, -52, 0};
    vecs[3]  = '{IN_C1, W_C1, 3'd2, 2'b11, 16, 0};
    vecs[4]  = '{IN_3, W_M128, 3'd0, 2'b00, -1536, 0};
    vecs[5]  = '{IN_3, W_M128, 3'd0, 2'b01, 0, 0};
    vecs[6]  = '{IN_3, W_M128, 3'd0, 2'b10, 1536, 0};
    vecs[7]  = '{IN_3, W_M128, 3'd0, 2'b11, 0, 0};
    vecs[8]  = '{8'h01, 32'h0000_0010, 3'd0, 2'b11, 12, 0};   // 16/4+8
    vecs[9]  = '{8'h00, W_P127, 3'd7, 2'b00, 112, 0};          // bias only
    vecs[10] = '{8'h01, 32'h0000_00F0, 3'd0, 2'b11, 4, 0};     // -16/4+8

    // reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_overflow", int'(overflow), 0);
    rst = 1'b0;

    // table-driven vectors on the default instance
    for (int i = 0; i < 11; i++) begin
      run_txn(vecs[i].in_v, vecs[i].w_v, vecs[i].b, vecs[i].act, d, o);
      check($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      check($sformatf("vec%0d_ovf", i), o, vecs[i].exp_ovf);
    end

    // saturation corners with ACC_W=10
    run_sat(IN_3, W_P127, 3'd0, 2'b00, d, o);
    check("sat_pos_data", d, 511);
    check("sat_pos_ovf", o, 1);
    run_sat(IN_C1, W_C1, 3'd2, 2'b00, d, o);
    check("sat_clean_data", d, 52);
    check("sat_clean_ovf", o, 0);
    run_sat(IN_3, W_M128, 3'd0, 2'b01, d, o);
    check("sat_neg_relu_data", d, 0);
    check("sat_neg_relu_ovf", o, 1);
    // -256 + -256 lands exactly on the minimum: no clamp in MAC
    run_sat({2'd0, 2'd0, 2'd2, 2'd2}, 32'h0000_8080, 3'd0, 2'b00, d, o);
    check("sat_min_data", d, -512);
    check("sat_min_ovf", o, 0);
    run_sat({2'd0, 2'd0, 2'd2, 2'd2}, 32'h0000_8080, 3'd0, 2'b10, d, o);
    check("neg_of_min_data", d, 511);
    check("neg_of_min_ovf", o, 1);

    // out_ready already high: handshake one edge after out_valid rises
    out_ready = 1'b1;
    @(negedge clk);
    in_vec = IN_C1; w_vec = W_C1; bias = 3'd2; act_sel = 2'b00; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    check("thru_latency", lat, 5);
    @(negedge clk);
    check("thru_out_valid_low", int'(out_valid), 0);
    check("thru_in_ready_high", int'(in_ready), 1);
    check("thru_data_held", int'($signed(out_data)), 52);
    out_ready = 1'b0;

    // backpressure; buses scrambled during MAC and DONE must not matter
    @(negedge clk);
    in_vec = IN_C1; w_vec = W_C1; bias = 3'd2; act_sel = 2'b10; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_vec = IN_3; w_vec = W_P127; bias = 3'd7; act_sel = 2'b11;
    lat = 0;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    check("bp_data", int'($signed(out_data)), -52);
    check("bp_ovf", int'(overflow), 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      in_vec   = 8'($urandom);
      w_vec    = $urandom;
      bias     = 3'($urandom);
      @(negedge clk);
      check($sformatf("bp%0d_out_valid", i), int'(out_valid), 1);
      check($sformatf("bp%0d_in_ready", i), int'(in_ready), 0);
      check($sformatf("bp%0d_data", i), int'($signed(out_data)), -52);
      check($sformatf("bp%0d_ovf", i), int'(overflow), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_out_valid", int'(out_valid), 0);
    check("bp_release_in_ready", int'(in_ready), 1);
    repeat (8) @(negedge clk);
    check("bp_nothing_accepted", int'(out_valid), 0);
    check("bp_idle_data_held", int'($signed(out_data)), -52);

    // reset in the second MAC cycle
    @(negedge clk);
    in_vec = IN_C1; w_vec = W_C1; bias = 3'd2; act_sel = 2'b00; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_out_data", int'(out_data), 0);
    check("midrst_overflow", int'(overflow), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_no_output", int'(out_valid), 0);
    run_txn(IN_C1, W_C1, 3'd2, 2'b00, d, o);
    check("post_rst_data", d, 52);
    check("post_rst_ovf", o, 0);

    // N_IN=8 latency
    @(negedge clk);
    l_in_vec = 16'h5555; l_w_vec = 64'h1010_1010_1010_1010;
    bias = 3'd0; act_sel = 2'b00; l_in_valid = 1'b1;
    @(negedge clk);
    l_in_valid = 1'b0;
    lat = 0;
    while (!l_out_valid && lat < 60) begin @(negedge clk); lat++; end
    check("n8_latency", lat, 9);
    check("n8_data", int'($signed(l_out_data)), 128);
    check("n8_ovf", int'(l_overflow), 0);
    l_out_ready = 1'b1;
    @(negedge clk);
    l_out_ready = 1'b0;
    check("n8_in_ready", int'(l_in_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
